fence_flush_ctrl: RTL and testbench
===================================

FENCE_FLUSH_CTRL -- requirements
Module: fence_flush_ctrl

Interface
REQ-001 SHALL have parameter FlushOnFence, default 1'b1: a fence flushes the dcache.
REQ-002 SHALL have parameter InvalidateOnFlush, default 1'b0: a dcache flush also invalidates.
REQ-003 SHALL have port clk_i, input, 1: the single clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port fence_valid_i, input, 1: fence request from commit.
REQ-006 SHALL have port fence_i_i, input, 1: request is fence.i; qualified by fence_valid_i.
REQ-007 SHALL have port fence_ready_o, output, 1: the block accepts a request.
REQ-008 SHALL have port stores_empty_i, input, 1: store buffer and outstanding stores drained.
REQ-009 SHALL have port dcache_flush_o, output, 1: dcache flush request, level.
REQ-010 SHALL have port dcache_invalidate_o, output, 1: invalidate qualifier, valid with dcache_flush_o.
REQ-011 SHALL have port dcache_flush_ack_i, input, 1: flush complete, single-cycle.
REQ-012 SHALL have port icache_flush_o, output, 1: icache flush, one-cycle pulse.
REQ-013 SHALL have port done_o, output, 1: fence complete, one-cycle pulse.
REQ-014 SHALL have port busy_o, output, 1: the FSM is not IDLE.
REQ-015 SHALL have port perf_cycles_o, output, 32: busy cycle count.
REQ-016 SHALL have port perf_fences_o, output, 32: completed fence count.

Function
REQ-017 SHALL implement FSM states IDLE, DRAIN, DC_FLUSH, IC_FLUSH, DONE.
REQ-018 SHALL drive fence_ready_o = (state==IDLE); a request is accepted on fence_valid_i & fence_ready_o, fence_i_i is latched, and the FSM goes to DRAIN.
REQ-019 SHALL, in DRAIN, hold while stores_empty_i=0; on stores_empty_i=1 go to DC_FLUSH if FlushOnFence, else to IC_FLUSH if the latched fence.i is set, else to DONE.
REQ-020 SHALL, in DC_FLUSH, assert dcache_flush_o every cycle, with dcache_invalidate_o=InvalidateOnFlush, until dcache_flush_ack_i=1 is sampled, including an ack in the first DC_FLUSH cycle; the FSM then goes to IC_FLUSH if fence.i, else to DONE.
REQ-021 SHALL ignore dcache_flush_ack_i outside DC_FLUSH.
REQ-022 SHALL assert icache_flush_o for exactly one cycle in IC_FLUSH, then go to DONE.
REQ-023 SHALL assert done_o for exactly one cycle in DONE, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-024 SHALL give a minimum latency, with FlushOnFence=0, plain fence and stores empty, of accept at cycle N, DRAIN at N+1, done_o at N+2.
REQ-025 SHALL make all outputs registered or derived from state only, with no combinational input-to-output path.

Reset
REQ-026 SHALL, on rst_i asserted at any time including mid-flush, asynchronously go to IDLE and drive fence_ready_o=1 with all other outputs 0 and the counters cleared; a flush in progress is abandoned without done_o.

Configuration
REQ-027 SHALL, with FENCE_FLUSH_PERF_EN defined, increment perf_cycles_o every cycle busy_o=1, saturating at 32'hFFFF_FFFF.
REQ-028 SHALL, with FENCE_FLUSH_PERF_EN defined, increment perf_fences_o on each done_o, wrapping modulo 2^32.
REQ-029 SHALL, without FENCE_FLUSH_PERF_EN, keep the perf ports and tie them to 0, with no counter flops.

Structure
REQ-030 SHALL define the FSM state enum fence_flush_state_e in a shared package fence_flush_pkg, alongside the perf counter width constant (32).
REQ-031 SHALL be a single module with no sub-module; the counters are inline under the macro.

Verification
REQ-032 SHALL cover: FlushOnFence=0, fence, stores_empty_i=1 -> done_o at accept+2, dcache_flush_o never high.
REQ-033 SHALL cover: FlushOnFence=1, fence, stores_empty_i low for 3 cycles, ack 4 cycles into DC_FLUSH -> dcache_flush_o high exactly 5 cycles, done_o 1 cycle later.
REQ-034 SHALL cover: fence.i, InvalidateOnFlush=1, ack in the first DC_FLUSH cycle -> dcache_invalidate_o=1 with flush, icache_flush_o 1-cycle pulse, then done_o.
REQ-035 SHALL cover: spurious dcache_flush_ack_i in IDLE and DRAIN -> no state change.
REQ-036 SHALL cover: rst_i asserted in DC_FLUSH -> same-cycle IDLE, outputs 0, no done_o, and the next fence completes normally.
REQ-037 SHALL cover: with FENCE_FLUSH_PERF_EN, two fences of 2 and 7 busy cycles -> perf_cycles_o=9, perf_fences_o=2; without it both read 0.

Source files
------------

// File: rtl/fence_flush_pkg.sv
// fence_flush_pkg: shared FSM state encoding and perf counter width for the fence/flush controller
package fence_flush_pkg;
  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    DC_FLUSH,
    IC_FLUSH,
    DONE
  } fence_flush_state_e;
  localparam int PerfW = 32;
endpackage

// File: rtl/fence_flush_ctrl.sv
// fence_flush_ctrl: sequences fence / fence.i through store drain, dcache flush and icache flush; FENCE_FLUSH_PERF_EN adds perf counters
module fence_flush_ctrl
  import fence_flush_pkg::*;
#(
  parameter logic FlushOnFence      = 1'b1,
  parameter logic InvalidateOnFlush = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fence_valid_i,
  input  logic             fence_i_i,
  output logic             fence_ready_o,
  input  logic             stores_empty_i,
  output logic             dcache_flush_o,
  output logic             dcache_invalidate_o,
  input  logic             dcache_flush_ack_i,
  output logic             icache_flush_o,
  output logic             done_o,
  output logic             busy_o,
  output logic [PerfW-1:0] perf_cycles_o,
  output logic [PerfW-1:0] perf_fences_o
);
  fence_flush_state_e state_q, state_d;
  logic fence_i_q;
  // state register and the fence.i flag captured at accept
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      fence_i_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fence_valid_i && state_q == IDLE) fence_i_q <= fence_i_i;
    end
  end
  // next state; outputs decode state only so no input reaches an output combinationally
  always_comb begin
    state_d             = state_q;
    fence_ready_o       = state_q == IDLE;
    dcache_flush_o      = state_q == DC_FLUSH;
    dcache_invalidate_o = state_q == DC_FLUSH && InvalidateOnFlush;
    icache_flush_o      = state_q == IC_FLUSH;
    done_o              = state_q == DONE;
    busy_o              = state_q != IDLE;
    case (state_q)
      IDLE:     state_d = fence_valid_i ? DRAIN : IDLE;
      DRAIN:    state_d = !stores_empty_i ? DRAIN : FlushOnFence ? DC_FLUSH : fence_i_q ? IC_FLUSH : DONE;
      DC_FLUSH: state_d = !dcache_flush_ack_i ? DC_FLUSH : fence_i_q ? IC_FLUSH : DONE;
      IC_FLUSH: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
`ifdef FENCE_FLUSH_PERF_EN
  // busy cycles saturate; completed fences wrap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cycles_o <= '0;
      perf_fences_o <= '0;
    end else begin
      if (busy_o && perf_cycles_o != '1) perf_cycles_o <= perf_cycles_o + 1'b1;
      if (done_o) perf_fences_o <= perf_fences_o + 1'b1;
    end
  end
`else
  assign perf_cycles_o = '0;
  assign perf_fences_o = '0;
`endif
endmodule

// File: tb/tb_fence_flush_ctrl.sv
// tb_fence_flush_ctrl: directed bench; instance 0 default params, 1 FlushOnFence=0, 2 InvalidateOnFlush=1
module tb_fence_flush_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid = 1'b0;
  logic fi = 1'b0;
  logic empty = 1'b1;
  logic ack = 1'b0;
  logic [2:0] ready, dfl, inv, ifl, done, busy;
  logic [31:0] pcyc [3];
  logic [31:0] pfen [3];
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  fence_flush_ctrl u_def (
    .clk_i(clk), .rst_i(rst), .fence_valid_i(valid), .fence_i_i(fi), .fence_ready_o(ready[0]),
    .stores_empty_i(empty), .dcache_flush_o(dfl[0]), .dcache_invalidate_o(inv[0]),
    .dcache_flush_ack_i(ack), .icache_flush_o(ifl[0]), .done_o(done[0]), .busy_o(busy[0]),
    .perf_cycles_o(pcyc[0]), .perf_fences_o(pfen[0])
  );
  fence_flush_ctrl #(.FlushOnFence(1'b0)) u_nf (
    .clk_i(clk), .rst_i(rst), .fence_valid_i(valid), .fence_i_i(fi), .fence_ready_o(ready[1]),
    .stores_empty_i(empty), .dcache_flush_o(dfl[1]), .dcache_invalidate_o(inv[1]),
    .dcache_flush_ack_i(ack), .icache_flush_o(ifl[1]), .done_o(done[1]), .busy_o(busy[1]),
    .perf_cycles_o(pcyc[1]), .perf_fences_o(pfen[1])
  );
  fence_flush_ctrl #(.InvalidateOnFlush(1'b1)) u_inv (
    .clk_i(clk), .rst_i(rst), .fence_valid_i(valid), .fence_i_i(fi), .fence_ready_o(ready[2]),
    .stores_empty_i(empty), .dcache_flush_o(dfl[2]), .dcache_invalidate_o(inv[2]),
    .dcache_flush_ack_i(ack), .icache_flush_o(ifl[2]), .done_o(done[2]), .busy_o(busy[2]),
    .perf_cycles_o(pcyc[2]), .perf_fences_o(pfen[2])
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    valid = 1'b0; fi = 1'b0; empty = 1'b1; ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    vecs++; if ({ready, dfl, inv, ifl, done, busy} !== {3'b111, 15'b0}) begin errs++; $display("FAIL reset_outs got=%b exp=%b", {ready, dfl, inv, ifl, done, busy}, {3'b111, 15'b0}); end
    for (int i = 0; i < 3; i++) begin
      vecs++; if (pcyc[i] !== 32'd0 || pfen[i] !== 32'd0) begin errs++; $display("FAIL reset_perf%0d got=%0d/%0d exp=0/0", i, pcyc[i], pfen[i]); end
    end
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    do_reset();
  endtask
  task automatic test_min_latency;
    do_reset();
    valid = 1'b1; fi = 1'b0; empty = 1'b1;
    tick();
    valid = 1'b0;
    vecs++; if (busy[1] !== 1'b1 || done[1] !== 1'b0) begin errs++; $display("FAIL min_drain got busy=%b done=%b exp busy=1 done=0", busy[1], done[1]); end
    tick();
    vecs++; if (done[1] !== 1'b1) begin errs++; $display("FAIL min_done got=%b exp=1", done[1]); end
    vecs++; if (dfl[1] !== 1'b0 || ifl[1] !== 1'b0) begin errs++; $display("FAIL min_noflush got dfl=%b ifl=%b exp 0", dfl[1], ifl[1]); end
    tick();
    vecs++; if (ready[1] !== 1'b1 || done[1] !== 1'b0 || busy[1] !== 1'b0) begin errs++; $display("FAIL min_idle got ready=%b done=%b busy=%b exp 1/0/0", ready[1], done[1], busy[1]); end
  endtask
  task automatic test_flush_wait;
    int n;
    do_reset();
    valid = 1'b1; fi = 1'b0; empty = 1'b0;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vecs++; if (busy[0] !== 1'b1 || dfl[0] !== 1'b0) begin errs++; $display("FAIL wait_drain%0d got busy=%b dfl=%b exp 1/0", i, busy[0], dfl[0]); end
      tick();
    end
    empty = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      ack = (i == 4);
      if (dfl[0] === 1'b1 && inv[0] === 1'b0) n++;
      tick();
    end
    ack = 1'b0;
    vecs++; if (n !== 5) begin errs++; $display("FAIL wait_flush_cycles got=%0d exp=5", n); end
    vecs++; if (dfl[0] !== 1'b0 || done[0] !== 1'b1 || ifl[0] !== 1'b0) begin errs++; $display("FAIL wait_done got dfl=%b done=%b ifl=%b exp 0/1/0", dfl[0], done[0], ifl[0]); end
    tick();
    vecs++; if (ready[0] !== 1'b1 || done[0] !== 1'b0) begin errs++; $display("FAIL wait_idle got ready=%b done=%b exp 1/0", ready[0], done[0]); end
  endtask
  task automatic test_fence_i;
    do_reset();
    valid = 1'b1; fi = 1'b1; empty = 1'b1;
    tick();
    valid = 1'b0; fi = 1'b0;
    tick();
    vecs++; if (dfl[2] !== 1'b1 || inv[2] !== 1'b1) begin errs++; $display("FAIL fi_inv got dfl=%b inv=%b exp 1/1", dfl[2], inv[2]); end
    vecs++; if (dfl[0] !== 1'b1 || inv[0] !== 1'b0) begin errs++; $display("FAIL fi_noinv got dfl=%b inv=%b exp 1/0", dfl[0], inv[0]); end
    vecs++; if (ifl[1] !== 1'b1 || dfl[1] !== 1'b0) begin errs++; $display("FAIL fi_noflush_ic got ifl=%b dfl=%b exp 1/0", ifl[1], dfl[1]); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vecs++; if (ifl[2] !== 1'b1 || dfl[2] !== 1'b0 || done[2] !== 1'b0) begin errs++; $display("FAIL fi_ic got ifl=%b dfl=%b done=%b exp 1/0/0", ifl[2], dfl[2], done[2]); end
    tick();
    vecs++; if (ifl[2] !== 1'b0 || done[2] !== 1'b1) begin errs++; $display("FAIL fi_done got ifl=%b done=%b exp 0/1", ifl[2], done[2]); end
    tick();
    vecs++; if (ready[2] !== 1'b1) begin errs++; $display("FAIL fi_idle got ready=%b exp 1", ready[2]); end
  endtask
  task automatic test_spurious_ack;
    do_reset();
    ack = 1'b1;
    tick();
    vecs++; if (ready[0] !== 1'b1 || busy[0] !== 1'b0) begin errs++; $display("FAIL spur_idle got ready=%b busy=%b exp 1/0", ready[0], busy[0]); end
    valid = 1'b1; empty = 1'b0;
    tick();
    valid = 1'b0;
    tick();
    vecs++; if (busy[0] !== 1'b1 || dfl[0] !== 1'b0 || done[0] !== 1'b0) begin errs++; $display("FAIL spur_drain got busy=%b dfl=%b done=%b exp 1/0/0", busy[0], dfl[0], done[0]); end
    ack = 1'b0; empty = 1'b1;
    tick();
    tick();
    vecs++; if (dfl[0] !== 1'b1 || done[0] !== 1'b0) begin errs++; $display("FAIL spur_flush_held got dfl=%b done=%b exp 1/0", dfl[0], done[0]); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vecs++; if (done[0] !== 1'b1) begin errs++; $display("FAIL spur_done got=%b exp=1", done[0]); end
  endtask
  task automatic test_reset_mid_flush;
    do_reset();
    valid = 1'b1; fi = 1'b0; empty = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    vecs++; if (dfl[0] !== 1'b1) begin errs++; $display("FAIL rst_pre got dfl=%b exp 1", dfl[0]); end
    #2 rst = 1'b1;
    #1;
    vecs++; if ({ready[0], dfl[0], inv[0], ifl[0], done[0], busy[0]} !== 6'b100000) begin errs++; $display("FAIL rst_mid got=%b exp=100000", {ready[0], dfl[0], inv[0], ifl[0], done[0], busy[0]}); end
    tick();
    rst = 1'b0;
    tick();
    vecs++; if (done[0] !== 1'b0 || ready[0] !== 1'b1) begin errs++; $display("FAIL rst_nodone got done=%b ready=%b exp 0/1", done[0], ready[0]); end
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vecs++; if (done[0] !== 1'b1) begin errs++; $display("FAIL rst_refence got done=%b exp 1", done[0]); end
  endtask
  task automatic test_back_to_back;
    do_reset();
    valid = 1'b1; fi = 1'b0; empty = 1'b1;
    tick();
    tick();
    vecs++; if (done[1] !== 1'b1 || ready[1] !== 1'b0) begin errs++; $display("FAIL b2b_done got done=%b ready=%b exp 1/0", done[1], ready[1]); end
    tick();
    vecs++; if (ready[1] !== 1'b1) begin errs++; $display("FAIL b2b_idle got ready=%b exp 1", ready[1]); end
    tick();
    valid = 1'b0;
    vecs++; if (busy[1] !== 1'b1 || done[1] !== 1'b0) begin errs++; $display("FAIL b2b_second got busy=%b done=%b exp 1/0", busy[1], done[1]); end
    tick();
    vecs++; if (done[1] !== 1'b1) begin errs++; $display("FAIL b2b_done2 got done=%b exp 1", done[1]); end
    tick();
  endtask
  task automatic test_perf;
    logic [31:0] exp_c, exp_f;
`ifdef FENCE_FLUSH_PERF_EN
    exp_c = 32'd9; exp_f = 32'd2;
`else
    exp_c = 32'd0; exp_f = 32'd0;
`endif
    do_reset();
    valid = 1'b1; fi = 1'b0; empty = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    valid = 1'b1; empty = 1'b0;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    empty = 1'b1;
    tick();
    vecs++; if (done[1] !== 1'b1) begin errs++; $display("FAIL perf_done got=%b exp=1", done[1]); end
    tick();
    vecs++; if (pcyc[1] !== exp_c) begin errs++; $display("FAIL perf_cycles got=%0d exp=%0d", pcyc[1], exp_c); end
    vecs++; if (pfen[1] !== exp_f) begin errs++; $display("FAIL perf_fences got=%0d exp=%0d", pfen[1], exp_f); end
  endtask
  initial begin
    test_reset();
    test_min_latency();
    test_flush_wait();
    test_fence_i();
    test_spurious_ack();
    test_reset_mid_flush();
    test_back_to_back();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
